// File: rtl/rng_request_arbiter.sv
// rtl/rng_request_arbiter.sv - round-robin arbiter sharing one pseudo-random source among N requesters
//
// Purpose:
//   Grants one requester at a time (round-robin from a rotating pointer),
//   gives the random source one clean enable pulse followed by a low gap,
//   captures the source's low W bits and folds them into [0, limit] by
//   repeated subtraction (one step per cycle), then returns the result with a
//   one-cycle, one-hot ack.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   req         per-requester level request, held until that requester's ack
//   limit_flat  per-requester inclusive upper bound, requester i at [i*W +: W]
//   ack         one-hot, one-cycle completion pulse for the served requester
//   rand_data   reduced random value, valid in the ack cycle, held until next ack
//   rand_id     id of the last served requester, updates with rand_data
//   busy        high in every state except IDLE
//   rng_enable  enable to the source; the source advances on its rising edge
//   rng_value   current output of the source (only [W-1:0] is used)

module rng_request_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   limit_flat,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     rand_data,
    output logic [IDW-1:0]   rand_id,
    output logic             busy,
    output logic             rng_enable,
    input  logic [31:0]      rng_value
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE   = 3'd1,
        GAP     = 3'd2,
        CAPTURE = 3'd3,
        REDUCE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    // State and datapath registers
    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [W-1:0]   glim_q, glim_d;
    logic [W-1:0]   acc_q, acc_d;

    // Registered outputs
    logic [N-1:0]   ack_q, ack_d;
    logic [W-1:0]   rand_data_q, rand_data_d;
    logic [IDW-1:0] rand_id_q, rand_id_d;
    logic           busy_q, busy_d;
    logic           rng_enable_q, rng_enable_d;

    // Grant search results
    logic [N-1:0]   req_hi;
    logic [N-1:0]   search;
    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   grant_lim;

    // Reduction step
    logic [W:0]     glim_p1;
    logic           acc_gt;
    logic [W-1:0]   acc_sub;
    logic [IDW-1:0] ptr_next;

    // Upper source bits are intentionally ignored.
    logic unused_rng_hi;
    assign unused_rng_hi = ^rng_value[31:W];

    // Round-robin search: prefer the lowest set request at or above the
    // pointer; if none exists there, wrap and take the lowest set request.
    always_comb begin : grant_search
        req_hi = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr_q));
        end
        search      = (req_hi != '0) ? req_hi : req;
        grant_valid = (req != '0);
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (search[i]) begin
                grant_idx = IDW'(i);
            end
        end
        grant_lim = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(grant_idx) == i) begin
                grant_lim = limit_flat[i*W +: W];
            end
        end
    end

    // glim+1 is formed one bit wider so a limit of all-ones does not wrap.
    always_comb begin : reduce_step
        glim_p1  = {1'b0, glim_q} + (W+1)'(1);
        acc_gt   = (acc_q > glim_q);
        acc_sub  = W'({1'b0, acc_q} - glim_p1);
        ptr_next = (gid_q == IDW'(N - 1)) ? '0 : gid_q + IDW'(1);
    end

    always_comb begin : next_state
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        glim_d      = glim_q;
        acc_d       = acc_q;
        rand_data_d = rand_data_q;
        rand_id_d   = rand_id_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    gid_d   = grant_idx;
                    glim_d  = grant_lim;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = GAP;
            end
            GAP: begin
                // Low phase after the pulse; the source updates meanwhile.
                state_d = CAPTURE;
            end
            CAPTURE: begin
                acc_d   = rng_value[W-1:0];
                state_d = REDUCE;
            end
            REDUCE: begin
                if (acc_gt) begin
                    acc_d = acc_sub;
                end else begin
                    // Result is loaded as we enter DONE so it is visible
                    // in the same cycle as the ack pulse.
                    rand_data_d = acc_q;
                    rand_id_d   = gid_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                ptr_d   = ptr_next;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up exactly with the state they belong to.
        rng_enable_d = (state_d == PULSE);
        busy_d       = (state_d != IDLE);
        ack_d        = '0;
        if (state_d == DONE) begin
            for (int i = 0; i < N; i++) begin
                ack_d[i] = (int'(gid_q) == i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gid_q        <= '0;
            glim_q       <= '0;
            acc_q        <= '0;
            ack_q        <= '0;
            rand_data_q  <= '0;
            rand_id_q    <= '0;
            busy_q       <= 1'b0;
            rng_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gid_q        <= gid_d;
            glim_q       <= glim_d;
            acc_q        <= acc_d;
            ack_q        <= ack_d;
            rand_data_q  <= rand_data_d;
            rand_id_q    <= rand_id_d;
            busy_q       <= busy_d;
            rng_enable_q <= rng_enable_d;
        end
    end

    assign ack        = ack_q;
    assign rand_data  = rand_data_q;
    assign rand_id    = rand_id_q;
    assign busy       = busy_q;
    assign rng_enable = rng_enable_q;

endmodule

// File: doc/rng_request_arbiter.md
Name: rng_request_arbiter

Overview:
- Shares the single pseudo-random number source among N game-logic requesters, e.g. ball-direction, player-spawn and bonus logic.
- Grants requesters round-robin and drives the source's edge-triggered enable with a clean pulse/gap pair.
- Captures the source's 8-bit value and reduces it into the requester's range [0, limit].
- Returns the reduced value with a one-cycle ack tagged with the requester id.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, result and limit width; only rng_value[W-1:0] is used
- IDW, 2, requester id width; must be at least ceil(log2 N)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N  per-requester level request; held high until that requester's ack
- limit_flat  in  N*W  per-requester inclusive upper bound; requester i uses bits [i*W +: W]
- ack  out  N  one-hot, one-cycle pulse marking completion for the granted requester
- rand_data  out  W  reduced random value; valid in the ack cycle, held until the next ack
- rand_id  out  IDW  id of the last served requester; updates with rand_data
- busy  out  1  high in every state except IDLE
- rng_enable  out  1  drives the source's enable; the source advances on a rising edge
- rng_value  in  32  current output of the source

Behaviour:
- Reset (synchronous): state <= IDLE; ack=0, rand_data=0, rand_id=0, busy=0, rng_enable=0; round-robin pointer <= 0, so requester 0 has top priority. Reset in any state aborts the transaction and no ack is issued.
- States: IDLE, PULSE, GAP, CAPTURE, REDUCE, DONE.
- IDLE: if any req bit is high, grant the first set bit searching from the pointer upward, modulo N.
  - Latch the granted id (gid) and its limit (glim).
  - Next state: PULSE. If no req is high, stay in IDLE.
- PULSE: rng_enable=1 for exactly one cycle. Next state: GAP.
- GAP: rng_enable=0. This guarantees a low phase between pulses and gives the source one cycle to update. Next state: CAPTURE.
- CAPTURE: acc <= rng_value[W-1:0]. Next state: REDUCE.
- REDUCE: one step per cycle.
  - If acc > glim, acc <= acc - (glim+1) and stay in REDUCE.
  - Otherwise go to DONE.
  - Use W+1-bit arithmetic for glim+1 so glim = 2^W-1 cannot overflow.
  - glim = 0 forces acc down to 0.
- DONE:
  - ack[gid]=1 and all other ack bits 0.
  - rand_data <= acc and rand_id <= gid, both registered and visible during the ack cycle.
  - pointer <= (gid+1) mod N.
  - Next state: IDLE.
- rng_enable is 0 in every state except PULSE.
- Latency: for a grant in cycle t0, ack fires in cycle t0+5+k, where k = floor(v/(glim+1)) and v is the captured value.
- req and limit are sampled only in IDLE. Changing limit or dropping req after the grant does not affect the transaction, and ack still pulses.
- A requester that drops req before it is granted is simply not served.
- Requester rule: drop req on the clock edge that ends the ack cycle. The IDLE state following DONE then sees the updated req. A req still high in that cycle counts as a new request.
- Simultaneous requests: only one is granted per transaction. The others stay pending and are served in round-robin order, so none starves.
- busy=1 from the PULSE state through the DONE state.

Test Plan:
- After reset, req=0001 with limit0=9; the source's first value is 0x12 (18) -> one PULSE, k=1; ack=0001 at t0+6, rand_data=8, rand_id=0; rng_enable high for exactly one cycle.
- After reset, req=0010 with limit1=255 -> rand_data=18 raw, k=0, ack=0010 at t0+5; second request gives 45; third gives 58.
- limit2=0 held continuously with req=0100 -> every ack returns rand_data=0; rng_enable always shows one-cycle pulses separated by at least 4 low cycles.
- req=1111 held with each requester dropping req after its ack -> ack order 0,1,2,3; with req=1111 held again, the next order is 0,1,2,3 again; no requester is served twice before another pending requester.
- Assert reset during REDUCE (limit=0 with captured value 58) -> no ack, and all outputs are 0 in the cycle after the reset edge; the next request is granted to requester 0 first.
- Change limit0 from 9 to 3 while busy is high -> result uses 9; drop req0 mid-transaction -> ack still pulses for requester 0.
